// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and the default operand width.
package div_seq_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

endpackage

// File: rtl/div_seq_sub_borrow.sv
// Unsigned N-bit subtractor with borrow out; the only arithmetic in the
// divider datapath.
module sub_borrow #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle MSB first, with a
// start/busy handshake. Optional macro DIV_ZERO_FAST_EN finishes b==0 in IDLE.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotWork_q;
  logic [WIDTH-1:0] ctr_q;
  logic [WIDTH:0]   partRem_q;

  logic [IW-1:0]    bitIdx;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   partRem_d;
  logic [WIDTH-1:0] quotWork_d;

  assign busy   = (state_q != IDLE);
  assign bitIdx = ctr_q[IW-1:0];

  // Bring down the next dividend bit: {r[WIDTH-1:0], dvd[ctr]}.
  assign shifted = (partRem_q << 1) | {{WIDTH{1'b0}}, dividend_q[bitIdx]};

  sub_borrow #(
    .N(WIDTH + 1)
  ) uSub (
    .a_i     (shifted),
    .b_i     ({1'b0, divisor_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  always_comb begin
    partRem_d          = borrow ? shifted : diff;
    quotWork_d         = quotWork_q;
    quotWork_d[bitIdx] = ~borrow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotWork_q  <= '0;
      ctr_q       <= '0;
      partRem_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef DIV_ZERO_FAST_EN
          if (start && (b_i == '0)) begin
            quotient    <= '1;
            remainder   <= a_i;
            div_by_zero <= 1'b1;
          end else if (start) begin
`else
          if (start) begin
`endif
            dividend_q <= a_i;
            divisor_q  <= b_i;
            partRem_q  <= '0;
            quotWork_q <= '0;
            ctr_q      <= WIDTH'(WIDTH - 1);
            state_q    <= STEP;
          end
        end
        STEP: begin
          partRem_q  <= partRem_d;
          quotWork_q <= quotWork_d;
          if (ctr_q == '0) begin
            // A zero divisor never borrows, so the normal path already yields all-ones / dividend.
            quotient    <= quotWork_d;
            remainder   <= partRem_d[WIDTH-1:0];
            div_by_zero <= (divisor_q == '0);
            state_q     <= IDLE;
          end else begin
            ctr_q <= ctr_q - WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, multi-cycle corner cases
// and a randomized sweep against an arithmetic reference model.
module tb_div_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         start;
  logic         busy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[8];

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_i        (a_i),
    .b_i        (b_i),
    .start      (start),
    .busy       (busy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic int expLat(input int b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 0 : W;
`else
    return W;
`endif
  endfunction

  function automatic int refQ(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int refR(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int eq, input int er, input int edz);
    int n;
    applyStimulus(a, b);
    waitIdle(n);
    checkOutput({tag, " latency"}, n, expLat(int'(b)));
    checkOutput({tag, " quotient"}, int'(quotient), eq);
    checkOutput({tag, " remainder"}, int'(remainder), er);
    checkOutput({tag, " div_by_zero"}, int'(div_by_zero), edz);
  endtask

  initial begin
    int n;
    int ra, rb;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[4] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, dz: 1'b1};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[6] = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[7] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2,  dz: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    #12;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset div_by_zero", int'(div_by_zero), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
            int'(vecs[i].q), int'(vecs[i].r), int'(vecs[i].dz));
      tick();
    end

    // start while busy is ignored; outputs hold the previous result mid-op
    applyStimulus(8'd200, 8'd3);
    tick();
    tick();
    checkOutput("ignore busy-high", int'(busy), 1);
    checkOutput("ignore hold quotient", int'(quotient), 42);
    a_i   = 8'd9;
    b_i   = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitIdle(n);
    checkOutput("ignore latency", n + 3, W);
    checkOutput("ignore quotient", int'(quotient), 66);
    checkOutput("ignore remainder", int'(remainder), 2);
    tick();
    checkOutput("ignore no queued op", int'(busy), 0);

    // asynchronous reset mid-operation
    applyStimulus(8'd200, 8'd3);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset quotient", int'(quotient), 0);
    checkOutput("midreset remainder", int'(remainder), 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("postreset idle", int'(busy), 0);
    runOp("after reset", 8'd50, 8'd5, 10, 0, 0);
    tick();

    // start held high: back-to-back ops with one IDLE cycle between
    a_i   = 8'd100;
    b_i   = 8'd7;
    start = 1'b1;
    tick();
    waitIdle(n);
    checkOutput("held first latency", n, W);
    checkOutput("held first quotient", int'(quotient), 14);
    checkOutput("held first remainder", int'(remainder), 2);
    a_i = 8'd9;
    b_i = 8'd2;
    tick();
    checkOutput("held second accepted", int'(busy), 1);
    start = 1'b0;
    waitIdle(n);
    checkOutput("held second latency", n, W);
    checkOutput("held second quotient", int'(quotient), 4);
    checkOutput("held second remainder", int'(remainder), 1);
    tick();

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) tick();
      runOp($sformatf("rand%0d %0d/%0d", i, ra, rb), W'(ra), W'(rb),
            refQ(ra, rb), refR(ra, rb), (rb == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
